benes_packed_unpacker: RTL and testbench

- Consumer end of the packed Benes datapath.
- Accepts full packed permuted words (DATA_WIDTH = E*FSIZE bits) from the network output stage via valid/ready.
- Buffers up to DEPTH words and drains each one as a stream of OUT_ELEMS-element beats to downstream logic.
- Marks the last beat of each word and counts completed frames.

---
 rtl/benes_packed_unpacker.sv | 162 ++++++++++++++++
 tb/tb_benes_packed_unpacker.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/benes_packed_unpacker.sv
// -----------------------------------------------------------------------------
// benes_packed_unpacker
//
// Consumer end of the packed Benes datapath. Full packed words (FSIZE elements
// of E bits) arrive from the network output stage through a valid/ready
// handshake. They are held in a small circular buffer of DEPTH words. Each
// word is then drained as BEATS consecutive beats of OUT_ELEMS elements each.
//
// Ports
//   clk        single clock, all state updates on the rising edge
//   rst        asynchronous, active-high reset
//   in_valid   a packed word is offered
//   in_ready   the buffer has room (derived from the registered count only)
//   in_data    packed word, element k at bits [k*E +: E]
//   out_valid  a beat is offered (buffer non-empty)
//   out_ready  downstream accepts the beat
//   out_data   current beat, element j at bits [j*E +: E]
//   out_last   the current beat is the final beat of its word
//   out_idx    index of the current beat within its word
//   frame_cnt  number of completely drained words since reset (wraps)
//   busy       the buffer holds at least one word
// -----------------------------------------------------------------------------
module benes_packed_unpacker #(
    parameter int E         = 8,
    parameter int FSIZE     = 64,
    parameter int OUT_ELEMS = 4,
    parameter int DEPTH     = 2,
    localparam int DATA_WIDTH = E * FSIZE,
    localparam int OUT_W      = E * OUT_ELEMS,
    localparam int BEATS      = FSIZE / OUT_ELEMS,
    localparam int BW         = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_W-1:0]      out_data,
    output logic                  out_last,
    output logic [BW-1:0]         out_idx,
    output logic [15:0]           frame_cnt,
    output logic                  busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);

    // Word storage. It is cleared on reset, so the stale slot visible while
    // the buffer is empty is well defined.
    logic [DATA_WIDTH-1:0] mem_reg [DEPTH];

    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg,  count_next;
    logic [BW-1:0] beat_reg,   beat_next;
    logic [15:0]   frame_cnt_reg, frame_cnt_next;

    logic push;
    logic beat_xfer;
    logic word_pop;

    logic [DATA_WIDTH-1:0] head_word;
    logic [OUT_W-1:0]      beat_slices [BEATS];

    // -------------------------------------------------------------------------
    // Handshake decode
    // -------------------------------------------------------------------------
    // in_ready looks only at the registered count, so a pop in the same cycle
    // does not open the buffer: there is no fall-through path.
    assign in_ready  = (count_reg < DEPTH_C);
    assign out_valid = (count_reg != '0);
    assign busy      = out_valid;

    assign push      = in_valid && in_ready;
    assign beat_xfer = out_valid && out_ready;
    assign word_pop  = beat_xfer && (beat_reg == LAST_BEAT);

    // -------------------------------------------------------------------------
    // Beat selection from the head word
    // -------------------------------------------------------------------------
    assign head_word = mem_reg[rd_ptr_reg];

    generate
        for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
            assign beat_slices[gi] = head_word[gi*OUT_W +: OUT_W];
        end
    endgenerate

    assign out_data  = beat_slices[beat_reg];
    assign out_idx   = beat_reg;
    assign out_last  = out_valid && (beat_reg == LAST_BEAT);
    assign frame_cnt = frame_cnt_reg;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        wr_ptr_next    = wr_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        count_next     = count_reg;
        beat_next      = beat_reg;
        frame_cnt_next = frame_cnt_reg;

        // DEPTH is a power of two, so plain increment wraps modulo DEPTH.
        if (push) begin
            wr_ptr_next = wr_ptr_reg + PW'(1);
        end

        if (beat_xfer) begin
            if (word_pop) begin
                beat_next      = '0;
                rd_ptr_next    = rd_ptr_reg + PW'(1);
                frame_cnt_next = frame_cnt_reg + 16'd1;
            end else begin
                beat_next = beat_reg + BW'(1);
            end
        end

        // A push together with a word pop leaves the occupancy unchanged.
        case ({push, word_pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            beat_reg      <= '0;
            frame_cnt_reg <= '0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            beat_reg      <= beat_next;
            frame_cnt_reg <= frame_cnt_next;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    mem_reg[gi] <= '0;
                end else if (push && (wr_ptr_reg == PW'(gi))) begin
                    mem_reg[gi] <= in_data;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_benes_packed_unpacker.sv
// -----------------------------------------------------------------------------
// tb_benes_packed_unpacker
//
// Directed self-checking bench for benes_packed_unpacker with default
// parameters (8-bit elements, 64 elements per word, 4 elements per beat,
// 2-word buffer). Inputs are driven 1 time unit after each rising edge and
// outputs are checked in that same window, before the next edge.
// -----------------------------------------------------------------------------
module tb_benes_packed_unpacker;

    localparam int E     = 8;
    localparam int FSIZE = 64;
    localparam int OE    = 4;
    localparam int DW    = E * FSIZE;
    localparam int OW    = E * OE;
    localparam int LIMIT = 20000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [OW-1:0] out_data;
    logic          out_last;
    logic [3:0]    out_idx;
    logic [15:0]   frame_cnt;
    logic          busy;

    benes_packed_unpacker #(
        .E(E), .FSIZE(FSIZE), .OUT_ELEMS(OE), .DEPTH(2)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_idx(out_idx),
        .frame_cnt(frame_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int frames_exp = 0;
    logic [7:0] base_q[$];
    int push_log[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // element k = base + k
    function automatic logic [DW-1:0] mkword(input logic [7:0] base);
        logic [DW-1:0] w;
        for (int k = 0; k < FSIZE; k++) w[k*E +: E] = base + 8'(k);
        return w;
    endfunction

    // element k = base ^ k
    function automatic logic [DW-1:0] mkword_x(input logic [7:0] base);
        logic [DW-1:0] w;
        for (int k = 0; k < FSIZE; k++) w[k*E +: E] = base ^ 8'(k);
        return w;
    endfunction

    // Expected beat b of a word built by mkword(base)
    function automatic logic [OW-1:0] exp_beat(input logic [7:0] base, input int b);
        logic [OW-1:0] r;
        for (int j = 0; j < OE; j++) r[j*E +: E] = base + 8'(b*OE + j);
        return r;
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"},  in_ready,  1);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_last"},  out_last,  0);
        chk({tag, "_out_idx"},   out_idx,   0);
        chk({tag, "_out_data"},  out_data,  0);
        chk({tag, "_busy"},      busy,      0);
        chk({tag, "_frame_cnt"}, frame_cnt, 0);
    endtask

    // Source pushes base_q[0..n_push-1]; sink drains and scores n_drain words
    // taken from base_q in order.
    task automatic run_stream(input int n_push, input int n_drain, input bit rnd,
                              output int bubbles);
        int pushed = 0;
        int done = 0;
        int cyc_s = 0;
        int cyc_k = 0;
        int beat = 0;
        bit started = 0;
        bit stalled = 0;
        logic [OW-1:0] held_data = '0;
        logic [3:0] held_idx = '0;
        bubbles = 0;
        push_log.delete();
        fork
            begin : src
                bit will;
                while (pushed < n_push && cyc_s < LIMIT) begin
                    if (!in_valid) in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                    in_data = mkword(base_q[pushed]);
                    will = in_valid && in_ready;
                    step();
                    cyc_s++;
                    if (will) begin
                        push_log.push_back(cyc_s - 1);
                        pushed++;
                        in_valid = 1'b0;
                    end
                end
                in_valid = 1'b0;
            end
            begin : snk
                bit xfer;
                while (done < n_drain && cyc_k < LIMIT) begin
                    out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                    if (out_valid) begin
                        started = 1;
                        chk("stream_data", out_data, exp_beat(base_q[done], beat));
                        chk("stream_idx",  out_idx,  beat);
                        chk("stream_last", out_last, beat == 15);
                        if (stalled) begin
                            chk("stall_data", out_data, held_data);
                            chk("stall_idx",  out_idx,  held_idx);
                        end
                    end else begin
                        chk("idle_last", out_last, 0);
                        if (started) bubbles++;
                    end
                    xfer      = out_valid && out_ready;
                    stalled   = out_valid && !out_ready;
                    held_data = out_data;
                    held_idx  = out_idx;
                    step();
                    cyc_k++;
                    if (xfer) begin
                        if (beat == 15) begin
                            beat = 0;
                            done++;
                        end else begin
                            beat++;
                        end
                    end
                end
                out_ready = 1'b0;
            end
        join
        chk("stream_pushed_all", pushed, n_push);
        chk("stream_drained_all", done, n_drain);
        frames_exp += done;
    endtask

    typedef struct {
        bit          in_valid;
        logic [7:0]  base;
        bit          out_ready;
        bit          e_in_ready;
        bit          e_out_valid;
        logic [3:0]  e_idx;
        bit          e_last;
        logic [31:0] e_data;
        logic [15:0] e_frame;
    } vec_t;

    vec_t vecs [18];

    initial begin
        int bub;
        int lim;

        // ---------------- table for test 1 ----------------
        vecs[0] = '{1, 8'h00, 1, 1, 0, 4'd0, 0, 32'h0, 16'd0};
        for (int i = 1; i <= 16; i++)
            vecs[i] = '{0, 8'h00, 1, 1, 1, 4'(i - 1), (i == 16), exp_beat(8'h00, i - 1), 16'd0};
        vecs[1].e_data  = 32'h03020100;
        vecs[2].e_data  = 32'h07060504;
        vecs[16].e_data = 32'h3F3E3D3C;
        vecs[17] = '{0, 8'h00, 1, 1, 0, 4'd0, 0, 32'h0, 16'd1};

        // ---------------- reset ----------------
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset_held");
        rst = 1'b0;
        step();
        chk_reset_outputs("reset_released");

        // ---------------- test 1: single word ----------------
        for (int i = 0; i < 18; i++) begin
            in_valid  = vecs[i].in_valid;
            in_data   = mkword(vecs[i].base);
            out_ready = vecs[i].out_ready;
            chk($sformatf("t1_in_ready[%0d]", i),  in_ready,  vecs[i].e_in_ready);
            chk($sformatf("t1_out_valid[%0d]", i), out_valid, vecs[i].e_out_valid);
            chk($sformatf("t1_busy[%0d]", i),      busy,      vecs[i].e_out_valid);
            chk($sformatf("t1_idx[%0d]", i),       out_idx,   vecs[i].e_idx);
            chk($sformatf("t1_last[%0d]", i),      out_last,  vecs[i].e_last);
            chk($sformatf("t1_data[%0d]", i),      out_data,  vecs[i].e_data);
            chk($sformatf("t1_frame[%0d]", i),     frame_cnt, vecs[i].e_frame);
            step();
        end
        in_valid = 1'b0;
        frames_exp = 1;
        $display("test1 single word: checks=%0d errors=%0d", checks, errors);

        // ---------------- test 2: three back-to-back words ----------------
        base_q = '{8'h00, 8'h40, 8'h80};
        run_stream(3, 3, 0, bub);
        chk("t2_bubbles", bub, 0);
        chk("t2_push_count", push_log.size(), 3);
        if (push_log.size() == 3) begin
            chk("t2_push0_cycle", push_log[0], 0);
            chk("t2_push1_cycle", push_log[1], 1);
            chk("t2_push2_cycle", push_log[2], 17);
        end
        chk("t2_frame_cnt", frame_cnt, frames_exp);
        chk("t2_busy", busy, 0);
        $display("test2 back-to-back: frame_cnt=%0d errors=%0d", frame_cnt, errors);

        // ---------------- test 3: fill while stalled ----------------
        in_valid = 1'b1; in_data = mkword(8'h00); out_ready = 1'b0;
        chk("t3_ready0", in_ready, 1);
        step();
        in_data = mkword(8'h40);
        chk("t3_ready1", in_ready, 1);
        chk("t3_valid1", out_valid, 1);
        step();
        in_data = mkword(8'h80);
        for (int i = 0; i < 20; i++) begin
            chk("t3_full_in_ready", in_ready, 0);
            chk("t3_hold_data", out_data, 32'h03020100);
            chk("t3_hold_idx", out_idx, 0);
            chk("t3_hold_last", out_last, 0);
            step();
        end
        in_valid = 1'b0;
        base_q = '{8'h00, 8'h40};
        run_stream(0, 2, 0, bub);
        chk("t3_busy_after", busy, 0);
        chk("t3_frame_cnt", frame_cnt, frames_exp);
        $display("test3 fill/stall: frame_cnt=%0d errors=%0d", frame_cnt, errors);

        // ---------------- test 4: random handshakes ----------------
        base_q.delete();
        for (int w = 0; w < 200; w++) base_q.push_back(8'(w * 37 + 3));
        run_stream(200, 200, 1, bub);
        chk("t4_frame_cnt", frame_cnt, frames_exp);
        chk("t4_busy", busy, 0);
        $display("test4 random 200 words: frame_cnt=%0d errors=%0d", frame_cnt, errors);

        // ---------------- test 5: async reset mid-word ----------------
        in_valid = 1'b1; in_data = mkword(8'h10); out_ready = 1'b1;
        step();
        in_data = mkword(8'h20);
        step();
        in_valid = 1'b0;
        lim = 0;
        while (out_idx != 4'd7 && lim < 20) begin
            step();
            lim++;
        end
        chk("t5_reach_beat7", out_idx, 7);
        chk("t5_busy_before", busy, 1);
        out_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk_reset_outputs("t5_async");
        @(posedge clk);
        #1 rst = 1'b0;
        chk_reset_outputs("t5_released");
        in_valid = 1'b1; in_data = mkword_x(8'hF0); out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("t5_valid", out_valid, 1);
        chk("t5_beat0", out_data, 32'hF3F2F1F0);
        chk("t5_idx0", out_idx, 0);
        chk("t5_frame0", frame_cnt, 0);
        repeat (16) step();
        chk("t5_frame1", frame_cnt, 1);
        chk("t5_busy_after", busy, 0);
        frames_exp = 1;
        $display("test5 async reset: frame_cnt=%0d errors=%0d", frame_cnt, errors);

        // ---------------- test 6: push on last-beat pop ----------------
        in_valid = 1'b1; in_data = mkword(8'h30); out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        lim = 0;
        while (out_idx != 4'd15 && lim < 20) begin
            step();
            lim++;
        end
        chk("t6_last", out_last, 1);
        in_valid = 1'b1; in_data = mkword(8'h50);
        chk("t6_in_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("t6_valid", out_valid, 1);
        chk("t6_idx0", out_idx, 0);
        chk("t6_beat0", out_data, exp_beat(8'h50, 0));
        chk("t6_count_one", in_ready, 1);
        chk("t6_frame", frame_cnt, frames_exp + 1);
        repeat (16) step();
        chk("t6_busy_after", busy, 0);
        chk("t6_frame_end", frame_cnt, frames_exp + 2);
        $display("test6 push on pop: frame_cnt=%0d errors=%0d", frame_cnt, errors);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
